// File: rtl/alu4_pkg.sv
// Shared definitions for the two-requester 4-bit ALU arbiter: widths, opcodes,
// FSM state encoding and the latched request payload.
package alu4_pkg;

  localparam int unsigned W    = 4;
  localparam int unsigned NREQ = 2;
  localparam int unsigned OPW  = 3;

  localparam logic [OPW-1:0] OP_AND  = 3'b000;
  localparam logic [OPW-1:0] OP_OR   = 3'b001;
  localparam logic [OPW-1:0] OP_XOR  = 3'b010;
  localparam logic [OPW-1:0] OP_NOT  = 3'b011;
  localparam logic [OPW-1:0] OP_ADD  = 3'b100;
  localparam logic [OPW-1:0] OP_SUB  = 3'b101;
  localparam logic [OPW-1:0] OP_CMP  = 3'b110;
  localparam logic [OPW-1:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           id;
  } req_t;

endpackage

// File: rtl/alu4_core.sv
// Purely combinational 4-bit ALU shared by both requesters; carry is the ADD
// carry-out or the SUB borrow and is 0 for every other opcode.
module alu4_core
  import alu4_pkg::*;
(
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   result,
  output logic           carry
);

  logic [W:0] sum;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    sum    = (W+1)'(a) + (W+1)'(b);
    unique case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_ADD: begin
        result = sum[W-1:0];
        carry  = sum[W];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_CMP:  result = {1'b0, (a > b), (a == b), (a < b)};
      default: result = a;
    endcase
  end

endmodule

// File: rtl/alu4_arbiter.sv
// Round-robin arbiter sharing one alu4_core between two valid/ready requesters,
// with a held response channel. Define ALU4_ARB_STATS_EN to add stat_grants.
module alu4_arbiter
  import alu4_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [OPW*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0]   req_a,
  input  logic [W*NREQ-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [W-1:0]        rsp_result,
  output logic                rsp_carry,
  output logic                rsp_zero
`ifdef ALU4_ARB_STATS_EN
  ,output logic [15:0]        stat_grants
`endif
);

  state_e       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  req_t         req_q, req_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_result_q, rsp_result_d;
  logic         rsp_carry_q, rsp_carry_d;
  logic         rsp_zero_q, rsp_zero_d;

  logic         grant;
  logic         accept;
  logic [W-1:0] core_result;
  logic         core_carry;

  alu4_core u_core (
    .op     (req_q.op),
    .a      (req_q.a),
    .b      (req_q.b),
    .result (core_result),
    .carry  (core_carry)
  );

  // Grant prefers the requester that did not win last time when both are valid.
  always_comb begin
    grant  = 1'b0;
    accept = 1'b0;
    if (state_q == ST_IDLE) begin
      unique case (req_valid)
        2'b01: begin grant = 1'b0;          accept = 1'b1; end
        2'b10: begin grant = 1'b1;          accept = 1'b1; end
        2'b11: begin grant = ~last_grant_q; accept = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    req_ready    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_ready[grant] = 1'b1;
          req_d.op     = grant ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
          req_d.a      = grant ? req_a[2*W-1:W]      : req_a[W-1:0];
          req_d.b      = grant ? req_b[2*W-1:W]      : req_b[W-1:0];
          req_d.id     = grant;
          last_grant_d = grant;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = core_result;
        rsp_carry_d  = core_carry;
        rsp_zero_d   = (core_result == '0);
        rsp_id_d     = req_q.id;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      req_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;

`ifdef ALU4_ARB_STATS_EN
  logic [7:0] cnt0_q, cnt0_d;
  logic [7:0] cnt1_q, cnt1_d;

  // Per-requester accept counters, saturating at 255.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (accept && !grant && (cnt0_q != 8'hFF)) cnt0_d = cnt0_q + 8'd1;
    if (accept &&  grant && (cnt1_q != 8'hFF)) cnt1_d = cnt1_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign stat_grants = {cnt1_q, cnt0_q};
`endif

endmodule

// File: doc/alu4_arbiter.md
Name: alu4_arbiter

Overview:
- Shares one 4-bit combinational ALU core between two requesters.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Each op result is registered together with its flags and the originating requester id.
- Result is held on a single response channel until the consumer accepts it. Sits between requester masters and the ALU datapath.

Parameters:
- W, 4, operand/result width (ALU is 4-bit; other values are not supported)
- NREQ, 2, number of requesters (fixed at 2; round-robin logic is written for 2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  request valid, one bit per requester
- req_ready  out  2  request accepted this cycle, one bit per requester
- req_op  in  6  opcode, 3 bits per requester ([2:0] req0, [5:3] req1)
- req_a  in  8  operand A, 4 bits per requester ([3:0] req0, [7:4] req1)
- req_b  in  8  operand B, same packing as req_a
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted by consumer
- rsp_id  out  1  requester index of the response
- rsp_result  out  4  ALU result
- rsp_carry  out  1  carry out (ADD) / borrow (SUB); 0 for other ops
- rsp_zero  out  1  rsp_result == 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all rsp_* outputs = 0; req_ready=0.
  - last_grant=1, so requester 0 wins the first tie.
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 NOT A
  - 100 ADD (5-bit sum; carry=bit4, result mod 16)
  - 101 SUB (A-B mod 16; carry=1 when A<B)
  - 110 CMP (result={1'b0, A>B, A==B, A<B})
  - 111 PASS A
- FSM states: IDLE, EXEC, RESP.
  - IDLE:
    - grant is combinational from req_valid and last_grant.
    - If exactly one requester is valid, it is granted.
    - If both are valid, grant goes to index != last_grant.
    - req_ready[g]=1 only for the granted index, and only in IDLE; all other req_ready bits are 0.
    - On handshake: latch op/a/b/id, set last_grant=g, go to EXEC.
  - EXEC (one cycle): drive the latched operands into the core, register result/carry/zero/id, set rsp_valid=1, go to RESP.
  - RESP:
    - Hold all rsp_* outputs stable while rsp_valid=1 and rsp_ready=0.
    - On rsp_ready=1, clear rsp_valid and go to IDLE.
    - rsp_result/flags retain their last values after rsp_valid clears.
- Latency and throughput:
  - Request accepted at edge N → rsp_valid high after edge N+1.
  - Minimum spacing between accepts is 3 cycles.
- No new request is accepted while in EXEC or RESP. req_valid may drop without acceptance (no penalty).
- rsp_ready high while in IDLE/EXEC: ignored.
- Reset mid-operation: the op is discarded, outputs return to reset values, and no response is produced.
- Unknown/X opcode handling is not required; all 8 codes are defined.

Optional Feature:
- Macro: ALU4_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants, 16 bits: [7:0] count of accepts for req0, [15:8] for req1.
  - Each count is 8-bit, saturating at 255, and increments on that requester's handshake.
  - Cleared by reset.
- Undefined: the port and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package alu4_pkg:
  - opcode localparams OP_AND..OP_PASS
  - state encoding ST_IDLE/ST_EXEC/ST_RESP
  - width constant W=4
- One sub-module, alu4_core:
  - purely combinational.
  - Inputs: op[2:0], a[3:0], b[3:0]. Outputs: result[3:0], carry.
  - Zero flag is computed in the arbiter.

Test Plan:
- Single request: req0 op=000, a=1010, b=1001 → one cycle later rsp_valid=1, rsp_id=0, rsp_result=1000, carry=0, zero=0.
- Contention fairness: both valid continuously with rsp_ready=1 → grant order 0,1,0,1 over 4 ops; each accept is 3 cycles apart.
- Arithmetic boundaries:
  - ADD 1111+0001 → result=0000, carry=1, zero=1.
  - SUB 0011-0101 → result=1110, carry=1.
  - CMP a=0111, b=0111 → result=0010.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → outputs stable, req_ready stays 0 despite req1 valid; rsp_ready=1 → IDLE, then req1 accepted next cycle.
- Async reset mid-op: assert rst_n=0 during EXEC → rsp_valid=0 immediately (before the next edge); after release, req0 wins the first tie.
- With ALU4_ARB_STATS_EN defined: 300 req0 accepts and 3 req1 accepts → stat_grants = {8'd3, 8'd255}.
